// File: rtl/twiddle_seq_if.sv
// Twiddle sequencer bus: control, ROM address/data and twiddle stream.
// master = sequencer side, slave = environment (ROM + butterfly consumer).
interface twiddle_seq_if #(
    parameter int NFFT = 32,
    parameter int W    = 16
);
    localparam int LOG2N = $clog2(NFFT);
    localparam int AW    = $clog2(NFFT/2);
    localparam int SW    = $clog2(LOG2N);

    logic          i_start;
    logic          i_abort;
    logic          o_busy;
    logic [AW-1:0] o_tw_addr;
    logic [W-1:0]  i_tw_re;
    logic [W-1:0]  i_tw_im;
    logic          o_valid;
    logic          i_ready;
    logic [W-1:0]  o_re;
    logic [W-1:0]  o_im;
    logic [SW-1:0] o_stage;
    logic [AW-1:0] o_bfly;
    logic          o_last;
    logic          o_done;

    modport master (
        input  i_start, i_abort, i_tw_re, i_tw_im, i_ready,
        output o_busy, o_tw_addr, o_valid, o_re, o_im, o_stage, o_bfly, o_last, o_done
    );
    modport slave (
        output i_start, i_abort, i_tw_re, i_tw_im, i_ready,
        input  o_busy, o_tw_addr, o_valid, o_re, o_im, o_stage, o_bfly, o_last, o_done
    );
endinterface

// File: rtl/twiddle_seq.sv
// Radix-2 DIT twiddle sequencer: walks stage/butterfly counters, addresses the
// twiddle ROM and streams registered twiddles over valid/ready.
module twiddle_seq #(
    parameter int NFFT = 32,
    parameter int W    = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    twiddle_seq_if.master bus
);
    localparam int LOG2N = $clog2(NFFT);
    localparam int AW    = $clog2(NFFT/2);
    localparam int SW    = $clog2(LOG2N);
    localparam logic [AW-1:0] KMAX = AW'(NFFT/2 - 1);
    localparam logic [SW-1:0] SMAX = SW'(LOG2N - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] stage_q, stage_d;
    logic [AW-1:0] bfly_q, bfly_d;
    logic          valid_q, valid_d;
    logic [W-1:0]  re_q, re_d, im_q, im_d;
    logic [SW-1:0] ostage_q, ostage_d;
    logic [AW-1:0] obfly_q, obfly_d;
    logic          last_q, last_d;
    logic          done_q, done_d;

    logic [AW:0]   mod_mask;
    logic [AW-1:0] addr;
    logic          is_last, load, hs;

    // Stage s uses twiddle index (k mod 2^s) * (N/2 >> s).
    always_comb begin
        mod_mask = ((AW+1)'(1) << stage_q) - (AW+1)'(1);
        addr     = (bfly_q & mod_mask[AW-1:0]) << (SMAX - stage_q);
    end

    assign is_last = (stage_q == SMAX) && (bfly_q == KMAX);
    assign load    = !valid_q || bus.i_ready;
    assign hs      = valid_q && bus.i_ready;

    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        bfly_d   = bfly_q;
        valid_d  = valid_q;
        re_d     = re_q;
        im_d     = im_q;
        ostage_d = ostage_q;
        obfly_d  = obfly_q;
        last_d   = last_q;
        done_d   = 1'b0;
        if (bus.i_abort) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            stage_d = '0;
            bfly_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (hs) valid_d = 1'b0;
                    if (bus.i_start) begin
                        state_d = S_RUN;
                        stage_d = '0;
                        bfly_d  = '0;
                    end
                end
                S_RUN: begin
                    if (load) begin
                        re_d     = bus.i_tw_re;
                        im_d     = bus.i_tw_im;
                        ostage_d = stage_q;
                        obfly_d  = bfly_q;
                        last_d   = is_last;
                        valid_d  = 1'b1;
                        if (is_last) begin
                            state_d = S_DRAIN;
                            stage_d = '0;
                            bfly_d  = '0;
                        end else if (bfly_q == KMAX) begin
                            bfly_d  = '0;
                            stage_d = stage_q + 1'b1;
                        end else begin
                            bfly_d  = bfly_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (hs) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            stage_q  <= '0;
            bfly_q   <= '0;
            valid_q  <= 1'b0;
            re_q     <= '0;
            im_q     <= '0;
            ostage_q <= '0;
            obfly_q  <= '0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            bfly_q   <= bfly_d;
            valid_q  <= valid_d;
            re_q     <= re_d;
            im_q     <= im_d;
            ostage_q <= ostage_d;
            obfly_q  <= obfly_d;
            last_q   <= last_d;
            done_q   <= done_d;
        end
    end

    assign bus.o_tw_addr = (state_q == S_RUN) ? addr : '0;
    assign bus.o_busy    = (state_q != S_IDLE);
    assign bus.o_valid   = valid_q;
    assign bus.o_re      = re_q;
    assign bus.o_im      = im_q;
    assign bus.o_stage   = ostage_q;
    assign bus.o_bfly    = obfly_q;
    assign bus.o_last    = last_q;
    assign bus.o_done    = done_q;
endmodule

// File: tb/tb_twiddle_seq.sv
// Directed bench for twiddle_seq at NFFT=32, W=16 with a combinational ROM model.
module tb_twiddle_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    twiddle_seq_if #(.NFFT(32), .W(16)) bus ();
    twiddle_seq #(.NFFT(32), .W(16)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    // Injective fake ROM contents so every address is distinguishable on o_re/o_im.
    function automatic logic [15:0] rom_re(input logic [3:0] a);
        return 16'(int'(a) * 257 + 3);
    endfunction
    function automatic logic [15:0] rom_im(input logic [3:0] a);
        return 16'(-(int'(a) * 131) - 1);
    endfunction
    function automatic logic [3:0] exp_addr(input int idx);
        int s, k;
        s = idx / 16;
        k = idx % 16;
        return 4'((k % (1 << s)) << (4 - s));
    endfunction

    always_comb begin
        bus.i_tw_re = rom_re(bus.o_tw_addr);
        bus.i_tw_im = rom_im(bus.o_tw_addr);
    end

    int hb[11] = '{0, 5, 16, 17, 18, 33, 34, 35, 36, 65, 79};
    int ha[11] = '{0, 0, 0, 8, 0, 4, 8, 12, 0, 1, 15};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_checks(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            chk("idle_valid", 32'(bus.o_valid), 0);
            chk("idle_busy", 32'(bus.o_busy), 0);
            chk("idle_done", 32'(bus.o_done), 0);
            chk("idle_addr", 32'(bus.o_tw_addr), 0);
            tick();
        end
    endtask

    // rmode 0: ready high, 1: random. start_at/abort_at: beat index or -1.
    task automatic run(input int rmode, input int start_at, input int abort_at,
                       input bit use_rst, input bit stall);
        int idx = 0, loaded, stall_cnt = 0;
        bit exp_done = 0, fin = 0, held = 0, rdy;
        logic [15:0] sv_re = '0, sv_im = '0;
        logic [2:0]  sv_st = '0;
        logic [3:0]  sv_bf = '0;
        logic        sv_ls = 1'b0;
        bus.i_ready = 1'b1;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            chk("done", 32'(bus.o_done), 32'(exp_done));
            if (exp_done) begin
                chk("done_busy", 32'(bus.o_busy), 0);
                fin = 1;
                break;
            end
            chk("busy", 32'(bus.o_busy), 1);
            if (held) begin
                chk("hold_re", 32'(bus.o_re), 32'(sv_re));
                chk("hold_im", 32'(bus.o_im), 32'(sv_im));
                chk("hold_stage", 32'(bus.o_stage), 32'(sv_st));
                chk("hold_bfly", 32'(bus.o_bfly), 32'(sv_bf));
                chk("hold_last", 32'(bus.o_last), 32'(sv_ls));
            end
            loaded = idx + int'(bus.o_valid);
            chk("addr", 32'(bus.o_tw_addr), (loaded < 80) ? 32'(exp_addr(loaded)) : 0);
            if (bus.o_valid) begin
                chk("stage", 32'(bus.o_stage), 32'(idx / 16));
                chk("bfly", 32'(bus.o_bfly), 32'(idx % 16));
                chk("re", 32'(bus.o_re), 32'(rom_re(exp_addr(idx))));
                chk("im", 32'(bus.o_im), 32'(rom_im(exp_addr(idx))));
                chk("last", 32'(bus.o_last), 32'(idx == 79));
                for (int j = 0; j < 11; j++)
                    if (hb[j] == idx) chk("hand_addr", 32'(bus.o_re), 32'(rom_re(4'(ha[j]))));
            end
            if (idx == abort_at) begin
                if (use_rst) rst_n = 1'b0;
                else bus.i_abort = 1'b1;
                tick();
                rst_n = 1'b1;
                bus.i_abort = 1'b0;
                chk("abort_valid", 32'(bus.o_valid), 0);
                if (use_rst) begin
                    chk("rst_re", 32'(bus.o_re), 0);
                    chk("rst_last", 32'(bus.o_last), 0);
                end
                idle_checks(4);
                return;
            end
            rdy = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall && bus.o_valid && idx == 79 && stall_cnt < 5) begin
                rdy = 1'b0;
                stall_cnt++;
                chk("drain_busy", 32'(bus.o_busy), 1);
                chk("drain_last", 32'(bus.o_last), 1);
            end
            bus.i_start = (idx == start_at);
            held  = bus.o_valid && !rdy;
            sv_re = bus.o_re; sv_im = bus.o_im; sv_st = bus.o_stage;
            sv_bf = bus.o_bfly; sv_ls = bus.o_last;
            if (bus.o_valid && rdy) begin
                if (idx == 79) exp_done = 1;
                idx++;
            end
            bus.i_ready = rdy;
            tick();
        end
        bus.i_start = 1'b0;
        bus.i_ready = 1'b1;
        if (!fin) chk("timeout", 0, 1);
        chk("beat_count", 32'(idx), 80);
        if (stall) chk("stall_cycles", 32'(stall_cnt), 5);
        tick();
        idle_checks(3);
    endtask

    initial begin
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        bus.i_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        chk("rst_re", 32'(bus.o_re), 0);
        chk("rst_im", 32'(bus.o_im), 0);
        chk("rst_stage", 32'(bus.o_stage), 0);
        chk("rst_bfly", 32'(bus.o_bfly), 0);
        chk("rst_last", 32'(bus.o_last), 0);
        idle_checks(5);

        run(0, -1, -1, 1'b0, 1'b0);
        run(1, -1, -1, 1'b0, 1'b0);
        run(0, 10, -1, 1'b0, 1'b0);
        run(0, -1, 37, 1'b0, 1'b0);
        run(0, -1, -1, 1'b0, 1'b0);
        run(0, -1, 37, 1'b1, 1'b0);
        run(1, -1, -1, 1'b0, 1'b0);
        run(0, -1, -1, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
